snake_frame_engine: RTL and testbench

- Parametrised successor to the static-shape pixel generator. Holds a moving snake on a cell grid, advances it once per STEP_FRAMES video frames, and detects wall and self collisions.
- Renders border, head and body to 4-bit RGB with one clock of latency.
- Sits between the VGA sync counter (pixel_x/pixel_y/video_on/frame_tick) and the DAC pins.

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_body.sv | 92 +++++++++
 rtl/snake_frame_engine.sv | 154 +++++++++++++++
 tb/tb_snake_frame_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake frame engine: directions, FSM states,
// 12-bit {R,G,B} colour words and the cell-coordinate width.
package snake_pkg;

    // Cell coordinates are 6 bits, so the grid can be at most 64x64 cells.
    localparam int CW = 6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam logic [11:0] COL_BORDER    = 12'hFFF;
    localparam logic [11:0] COL_HEAD      = 12'h0F0;
    localparam logic [11:0] COL_BODY      = 12'h080;
    localparam logic [11:0] COL_DEAD_HEAD = 12'hF00;
    localparam logic [11:0] COL_DEAD_BODY = 12'h800;

    // Opposite directions differ only in bit 1 (up/down, right/left).
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_body.sv
// Segment store of the snake: shift register of cell positions (seg[0] is
// the head), length counter, and the parallel comparators used for
// self-collision and for pixel rendering.
module snake_body
    import snake_pkg::*;
#(
    parameter int H_CELLS = 40,
    parameter int V_CELLS = 30,
    parameter int MAX_LEN = 16
) (
    input  logic          clk_d,
    input  logic          rst_n,
    input  logic          reload,
    input  logic          step,
    input  logic          grow_en,
    input  logic [CW-1:0] new_x,
    input  logic [CW-1:0] new_y,
    input  logic [CW-1:0] qx,
    input  logic [CW-1:0] qy,
    output logic [CW-1:0] head_x,
    output logic [CW-1:0] head_y,
    output logic [4:0]    length,
    output logic          self_hit,
    output logic          seg_hit,
    output logic          head_hit
);

    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CW-1:0] seg_y [MAX_LEN];
    logic          grow_ok;

    // Start layout: head in the grid centre, two body cells trailing to the left.
    function automatic logic [CW-1:0] init_x(input int i);
        return (i < 3) ? CW'(H_CELLS / 2 - i) : '0;
    endfunction

    function automatic logic [CW-1:0] init_y(input int i);
        return (i < 3) ? CW'(V_CELLS / 2) : '0;
    endfunction

    // A grow request at full length is swallowed without effect.
    assign grow_ok = grow_en && (int'(length) < MAX_LEN);
    assign head_x  = seg_x[0];
    assign head_y  = seg_y[0];

    // Shift the segments on each committed step; the old tail survives in
    // seg[length] and becomes live when the length counter advances.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
            length <= 5'd3;
        end else if (reload) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
            length <= 5'd3;
        end else if (step) begin
            seg_x[0] <= new_x;
            seg_y[0] <= new_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            if (grow_ok) length <= length + 5'd1;
        end
    end

    // Candidate head against the body; the tail only counts when it stays put.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (seg_x[i] == new_x && seg_y[i] == new_y &&
                (i < int'(length) - 1 || (grow_ok && i == int'(length) - 1)))
                self_hit = 1'b1;
        end
    end

    // Pixel query: head and live body cells at (qx, qy).
    always_comb begin
        head_hit = (seg_x[0] == qx) && (seg_y[0] == qy);
        seg_hit  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (i < int'(length) && seg_x[i] == qx && seg_y[i] == qy)
                seg_hit = 1'b1;
        end
    end

endmodule

// File: rtl/snake_frame_engine.sv
// Snake game engine between the VGA sync counter and the DAC: game FSM,
// frame-based step timing, direction filtering, wall check and a
// one-clock registered colour output.
module snake_frame_engine
    import snake_pkg::*;
#(
    parameter int CELL_SHIFT  = 4,
    parameter int H_CELLS     = 40,
    parameter int V_CELLS     = 30,
    parameter int MAX_LEN     = 16,
    parameter int STEP_FRAMES = 8
) (
    input  logic       clk_d,
    input  logic       rst_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [1:0] dir,
    input  logic       grow,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [4:0] length,
    output logic       game_over
);

    localparam int SCW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    logic [1:0]    state;
    logic [1:0]    cur_dir, next_dir, ref_dir;
    logic [SCW-1:0] step_cnt;
    logic          grow_pend, grow_en;
    logic          step_fire, reload, wall_hit, self_hit, collide;
    logic [CW-1:0] head_x, head_y, new_x, new_y;
    logic [9:0]    px_cell, py_cell;
    logic          seg_hit, head_hit, border;
    logic [11:0]   rgb_p1;

    assign step_fire = (state == ST_RUN) && frame_tick && (step_cnt == SCW'(STEP_FRAMES - 1));
    assign reload    = (state == ST_OVER) && start;
    assign grow_en   = grow_pend || grow;
    // Reversal is judged against the direction the snake will be moving in.
    assign ref_dir   = step_fire ? next_dir : cur_dir;

    // Candidate head one cell along the direction latched for this step.
    always_comb begin
        new_x = head_x;
        new_y = head_y;
        case (next_dir)
            DIR_UP:    new_y = head_y - CW'(1);
            DIR_RIGHT: new_x = head_x + CW'(1);
            DIR_DOWN:  new_y = head_y + CW'(1);
            default:   new_x = head_x - CW'(1);
        endcase
    end

    assign wall_hit = (new_x == '0) || (new_x == CW'(H_CELLS - 1)) ||
                      (new_y == '0) || (new_y == CW'(V_CELLS - 1));
    assign collide  = wall_hit || self_hit;

    snake_body #(
        .H_CELLS (H_CELLS),
        .V_CELLS (V_CELLS),
        .MAX_LEN (MAX_LEN)
    ) u_body (
        .clk_d    (clk_d),
        .rst_n    (rst_n),
        .reload   (reload),
        .step     (step_fire && !collide),
        .grow_en  (grow_en),
        .new_x    (new_x),
        .new_y    (new_y),
        .qx       (px_cell[CW-1:0]),
        .qy       (py_cell[CW-1:0]),
        .head_x   (head_x),
        .head_y   (head_y),
        .length   (length),
        .self_hit (self_hit),
        .seg_hit  (seg_hit),
        .head_hit (head_hit)
    );

    // Game FSM: IDLE -> RUN on start, RUN -> OVER on collision, OVER -> IDLE on start.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                ST_RUN:  if (step_fire && collide) state <= ST_OVER;
                ST_OVER: if (start) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Frame counter and pending grow, both live only while running.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt  <= '0;
            grow_pend <= 1'b0;
        end else if (reload) begin
            step_cnt  <= '0;
            grow_pend <= 1'b0;
        end else if (state == ST_RUN) begin
            if (frame_tick) step_cnt <= step_fire ? '0 : step_cnt + SCW'(1);
            if (step_fire)  grow_pend <= 1'b0;
            else if (grow)  grow_pend <= 1'b1;
        end
    end

    // Direction request filter; the accepted request becomes cur_dir at a step.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            cur_dir  <= DIR_RIGHT;
            next_dir <= DIR_RIGHT;
        end else if (reload) begin
            cur_dir  <= DIR_RIGHT;
            next_dir <= DIR_RIGHT;
        end else begin
            if (step_fire) cur_dir <= next_dir;
            if (!is_reverse(dir, ref_dir)) next_dir <= dir;
        end
    end

    assign px_cell = pixel_x >> CELL_SHIFT;
    assign py_cell = pixel_y >> CELL_SHIFT;
    assign border  = (px_cell == '0) || (px_cell == 10'(H_CELLS - 1)) ||
                     (py_cell == '0) || (py_cell == 10'(V_CELLS - 1));

    // Colour register: prioritised blanking, border, head, body.
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n)
            rgb_p1 <= '0;
        else if (!video_on || px_cell >= 10'(H_CELLS) || py_cell >= 10'(V_CELLS))
            rgb_p1 <= '0;
        else if (border)
            rgb_p1 <= COL_BORDER;
        else if (head_hit)
            rgb_p1 <= (state == ST_OVER) ? COL_DEAD_HEAD : COL_HEAD;
        else if (seg_hit)
            rgb_p1 <= (state == ST_OVER) ? COL_DEAD_BODY : COL_BODY;
        else
            rgb_p1 <= '0;
    end

    assign red       = rgb_p1[11:8];
    assign green     = rgb_p1[7:4];
    assign blue      = rgb_p1[3:0];
    assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_snake_frame_engine.sv
// Directed bench for snake_frame_engine: movement, direction filtering,
// wall and self collisions, growth saturation and rendering priority.
module tb_snake_frame_engine;

    logic       clk_d = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       video_on = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dir = 2'd1;
    logic       grow = 1'b0;
    logic [3:0] red, green, blue;
    logic [4:0] length;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    snake_frame_engine dut (
        .clk_d      (clk_d),
        .rst_n      (rst_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .start      (start),
        .dir        (dir),
        .grow       (grow),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .length     (length),
        .game_over  (game_over)
    );

    always #5 clk_d = ~clk_d;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_d);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic step();
        repeat (8) tick();
    endtask

    // grow asserted together with the final frame_tick of the step
    task automatic step_grow();
        repeat (7) tick();
        frame_tick = 1'b1;
        grow = 1'b1;
        cyc();
        frame_tick = 1'b0;
        grow = 1'b0;
        cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        cyc();
        grow = 1'b0;
    endtask

    task automatic see_pix(input string tag, input int px, input int py, input logic vo,
                           input logic [11:0] exp);
        pixel_x  = 10'(px);
        pixel_y  = 10'(py);
        video_on = vo;
        cyc();
        check_val(tag, {20'd0, red, green, blue}, {20'd0, exp});
    endtask

    task automatic see_cell(input string tag, input int cx, input int cy, input logic [11:0] exp);
        see_pix(tag, cx * 16 + 8, cy * 16 + 8, 1'b1, exp);
    endtask

    initial begin
        pixel_x  = 10'd328;
        pixel_y  = 10'd248;
        video_on = 1'b1;
        repeat (3) cyc();
        check_val("reset_rgb", {20'd0, red, green, blue}, 32'h000);
        check_val("reset_over", {31'd0, game_over}, 32'd0);
        check_val("reset_len", {27'd0, length}, 32'd3);
        rst_n = 1'b1;
        cyc();

        // Idle: layout visible, frame ticks do not move the snake.
        see_cell("idle_head", 20, 15, 12'h0F0);
        see_cell("idle_body", 18, 15, 12'h080);
        step();
        see_cell("idle_nomove", 21, 15, 12'h000);

        // Run: seven ticks do nothing, the eighth steps right.
        pulse_start();
        repeat (7) tick();
        see_cell("seven_ticks", 20, 15, 12'h0F0);
        tick();
        see_pix("step1_head", 336, 240, 1'b1, 12'h0F0);
        see_cell("step1_body", 19, 15, 12'h080);
        see_cell("step1_vacated", 18, 15, 12'h000);
        check_val("step1_len", {27'd0, length}, 32'd3);

        // Reverse request ignored, then turn up.
        dir = 2'd3;
        cyc();
        step();
        see_cell("rev_ignored", 22, 15, 12'h0F0);
        dir = 2'd0;
        step();
        see_cell("turn_up", 22, 14, 12'h0F0);
        see_cell("turn_body", 22, 15, 12'h080);

        // Run right into the east wall.
        dir = 2'd1;
        for (int k = 1; k <= 16; k++) step();
        see_cell("at_x38", 38, 14, 12'h0F0);
        check_val("pre_wall_over", {31'd0, game_over}, 32'd0);
        step();
        check_val("wall_over", {31'd0, game_over}, 32'd1);
        see_cell("wall_dead_head", 38, 14, 12'hF00);
        see_cell("wall_dead_body", 37, 14, 12'h800);
        check_val("wall_len", {27'd0, length}, 32'd3);
        step();
        see_cell("over_frozen", 38, 14, 12'hF00);

        // start in OVER reloads the layout.
        pulse_start();
        check_val("reload_over", {31'd0, game_over}, 32'd0);
        see_cell("reload_head", 20, 15, 12'h0F0);
        see_cell("reload_body", 18, 15, 12'h080);
        see_cell("reload_old", 38, 14, 12'h000);

        // grow in IDLE is ignored.
        pulse_grow();
        pulse_start();
        step();
        check_val("idle_grow_ignored", {27'd0, length}, 32'd3);
        see_cell("run2_head", 21, 15, 12'h0F0);

        // Twenty grow/step pairs: length saturates at 16.
        for (int k = 1; k <= 20; k++) begin
            if (k == 16) dir = 2'd2;
            pulse_grow();
            step();
            if (k == 1)  check_val("grow_len1", {27'd0, length}, 32'd4);
            if (k == 13) check_val("grow_len13", {27'd0, length}, 32'd16);
            if (k == 14) check_val("grow_len14", {27'd0, length}, 32'd16);
        end
        check_val("grow_len20", {27'd0, length}, 32'd16);
        check_val("grow_alive", {31'd0, game_over}, 32'd0);
        see_cell("long_head", 36, 20, 12'h0F0);
        see_cell("long_tail", 26, 15, 12'h080);
        see_cell("long_past_tail", 25, 15, 12'h000);

        // Reverse (up while moving down) ignored.
        dir = 2'd0;
        step();
        see_cell("long_rev", 36, 21, 12'h0F0);

        // Right, up, left into own body.
        dir = 2'd1;
        step();
        dir = 2'd0;
        step();
        check_val("self_pre", {31'd0, game_over}, 32'd0);
        dir = 2'd3;
        step();
        check_val("self_over", {31'd0, game_over}, 32'd1);
        see_cell("self_dead_head", 37, 20, 12'hF00);
        see_cell("self_dead_body", 36, 20, 12'h800);
        check_val("self_len", {27'd0, length}, 32'd16);

        // Length 4, circle into the vacating tail cell.
        pulse_start();
        dir = 2'd1;
        pulse_start();
        step_grow();
        check_val("same_cycle_grow", {27'd0, length}, 32'd4);
        dir = 2'd2;
        step();
        dir = 2'd3;
        step();
        dir = 2'd0;
        step();
        check_val("tail_no_hit", {31'd0, game_over}, 32'd0);
        see_cell("tail_head", 20, 15, 12'h0F0);
        see_cell("tail_body", 21, 15, 12'h080);
        see_cell("tail_vacated", 19, 15, 12'h000);
        check_val("tail_len", {27'd0, length}, 32'd4);

        // Same move into the tail while growing collides.
        pulse_grow();
        dir = 2'd1;
        step();
        check_val("tail_grow_hit", {31'd0, game_over}, 32'd1);
        check_val("tail_grow_len", {27'd0, length}, 32'd4);
        see_cell("tail_dead_head", 20, 15, 12'hF00);
        see_cell("tail_dead_body", 21, 15, 12'h800);

        // Rendering priority.
        see_pix("video_off", 328, 248, 1'b0, 12'h000);
        see_pix("border_00", 0, 0, 1'b1, 12'hFFF);
        see_pix("border_br", 639, 479, 1'b1, 12'hFFF);
        see_pix("off_grid", 648, 8, 1'b1, 12'h000);

        pulse_start();
        check_val("final_idle", {31'd0, game_over}, 32'd0);
        check_val("final_len", {27'd0, length}, 32'd3);
        see_cell("final_head", 20, 15, 12'h0F0);
        see_cell("final_body", 19, 15, 12'h080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
